// File: rtl/aes_pkg.sv
// AES primitives shared by the iterative cipher: FSM encoding, Rcon, S-box, xtime.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYEXP = 2'd1,
    ST_ROUND  = 2'd2,
    ST_DONE   = 2'd3
  } aes_state_e;

  // Element i holds Rcon[i]; only 1..10 are ever addressed.
  localparam logic [15:0][7:0] RCON = {
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
    8'h00
  };

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte x sits at bits [8*(255-x)+7 -: 8] of the table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when last_i), AddRoundKey.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rkey_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  // Byte n of the state is element n (element 0 is bits 127:120); column c is bytes 4c..4c+3.
  logic [0:15][7:0] s_in, sb, sr, mc, rk, res;

  assign s_in    = state_i;
  assign rk      = rkey_i;
  assign state_o = res;

  always_comb begin
    sb  = '0;
    sr  = '0;
    mc  = '0;
    res = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s_in[i]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++) res[i] = (last_i ? sr[i] : mc[i]) ^ rk[i];
  end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 encryptor: on-the-fly key expansion (one word/cycle), then one round/cycle.
// Optional AES_KEY_CACHE_EN skips key expansion when the key matches the last fully expanded one.
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int unsigned NK = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_vld,
  output logic            o_rdy,
  input  logic [127:0]    in,
  input  logic [32*NK-1:0] i_key,
  output logic [127:0]    out,
  output logic            o_vld,
  input  logic            i_rdy
);

  localparam int unsigned NR = NK + 6;
  localparam int unsigned NW = 4 * (NR + 1);
  localparam int unsigned KW = 32 * NK;

  aes_state_e     state_q, state_d;
  logic [127:0]   st_q, st_d;
  logic [127:0]   out_q, out_d;
  logic           vld_q, vld_d;
  logic           rdy_q, rdy_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [5:0]     widx_q, widx_d;
  logic [31:0]    w_q [NW];

  logic           accept_c, hit_c, last_c, kexp_done_c;
  logic [3:0]     rnd_cur_c;
  logic [5:0]     kmod_c;
  logic [31:0]    prev_c, temp_c, wnew_c;
  logic [127:0]   rkey_c, rnd_out_c;

  assign accept_c    = i_vld && rdy_q;
  assign kexp_done_c = (state_q == ST_KEYEXP) && (widx_q == 6'(NW - 1));
  assign rnd_cur_c   = rnd_q + 4'd1;
  assign last_c      = (rnd_cur_c == 4'(NR));
  assign rkey_c      = {w_q[{rnd_cur_c, 2'b00}], w_q[{rnd_cur_c, 2'b01}],
                        w_q[{rnd_cur_c, 2'b10}], w_q[{rnd_cur_c, 2'b11}]};

  assign o_rdy = rdy_q;
  assign o_vld = vld_q;
  assign out   = out_q;

`ifdef AES_KEY_CACHE_EN
  logic [KW-1:0] ckey_q;
  logic          cvld_q;

  // Flag goes low while a new key is being expanded and rises once its schedule is complete.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ckey_q <= '0;
      cvld_q <= 1'b0;
    end else if (accept_c && !hit_c) begin
      ckey_q <= i_key;
      cvld_q <= 1'b0;
    end else if (kexp_done_c) begin
      cvld_q <= 1'b1;
    end
  end

  assign hit_c = cvld_q && (i_key == ckey_q);
`else
  assign hit_c = 1'b0;
`endif

  // Next schedule word for index widx_q.
  always_comb begin
    kmod_c = widx_q % 6'(NK);
    prev_c = w_q[widx_q - 6'd1];
    temp_c = prev_c;
    if (kmod_c == 6'd0)
      temp_c = sub_word({prev_c[23:0], prev_c[31:24]}) ^ {RCON[4'(widx_q / 6'(NK))], 24'h0};
    else if (NK == 8 && kmod_c == 6'd4)
      temp_c = sub_word(prev_c);
    wnew_c = w_q[widx_q - 6'(NK)] ^ temp_c;
  end

  aes_round_comb u_round (
    .state_i (st_q),
    .rkey_i  (rkey_c),
    .last_i  (last_c),
    .state_o (rnd_out_c)
  );

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    out_d   = out_q;
    vld_d   = vld_q;
    rnd_d   = rnd_q;
    widx_d  = widx_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          st_d    = in ^ i_key[KW-1 -: 128];
          rnd_d   = 4'd0;
          widx_d  = 6'(NK);
          state_d = hit_c ? ST_ROUND : ST_KEYEXP;
        end
      end
      ST_KEYEXP: begin
        if (kexp_done_c) state_d = ST_ROUND;
        else             widx_d  = widx_q + 6'd1;
      end
      ST_ROUND: begin
        st_d  = rnd_out_c;
        rnd_d = rnd_cur_c;
        if (last_c) begin
          out_d   = rnd_out_c;
          vld_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_rdy) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      st_q    <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
      rnd_q   <= '0;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
      rnd_q   <= rnd_d;
      widx_q  <= widx_d;
    end
  end

  // Schedule storage carries no reset; every word read is written first for the current key.
  always_ff @(posedge i_clk) begin
    if (accept_c) begin
      for (int i = 0; i < int'(NK); i++) w_q[i] <= i_key[KW-1-32*i -: 32];
    end else if (state_q == ST_KEYEXP) begin
      w_q[widx_q] <= wnew_c;
    end
  end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Scoreboard bench for aes_cipher_iter at NK=4/6/8; honours AES_KEY_CACHE_EN when defined.
module tb_aes_cipher_iter;

  typedef struct {
    logic [127:0] ct;
    int           lat;
    int           acc;
  } exp_t;

  localparam logic [255:0] K_SEQ  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K_B    = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K_Z    = 256'h0;
  localparam logic [127:0] PT_A   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] PT_Z   = 128'h0;
  localparam logic [127:0] CT_A4  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_A6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_A8  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT_B4  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_Z4  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] CT_Z8  = 128'hdc95c078a2408989ad48a21492842087;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         drv_vld = 1'b0;
  logic         drv_rdy = 1'b1;
  logic [127:0] drv_pt = '0;
  logic [255:0] drv_key = '0;
  logic [1:0]   sel = 2'd0;
  logic [2:0]   ivld_w, rdy_w, ovld_w;
  logic [127:0] ct_w [3];
  logic         obs_vld, obs_rdy, mon_prev;
  logic [127:0] obs_out;
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  exp_t         sb_q[$];
  exp_t         mon_e;
`ifdef AES_KEY_CACHE_EN
  logic         mc_vld [3];
  logic [255:0] mc_key [3];
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ivld_w  = {drv_vld && sel == 2'd2, drv_vld && sel == 2'd1, drv_vld && sel == 2'd0};
  assign obs_vld = ovld_w[sel];
  assign obs_rdy = rdy_w[sel];
  assign obs_out = ct_w[sel];

  aes_cipher_iter #(.NK(4)) u_nk4 (
    .i_clk(clk), .i_rst(rst), .i_vld(ivld_w[0]), .o_rdy(rdy_w[0]), .in(drv_pt),
    .i_key(drv_key[255:128]), .out(ct_w[0]), .o_vld(ovld_w[0]), .i_rdy(drv_rdy));
  aes_cipher_iter #(.NK(6)) u_nk6 (
    .i_clk(clk), .i_rst(rst), .i_vld(ivld_w[1]), .o_rdy(rdy_w[1]), .in(drv_pt),
    .i_key(drv_key[255:64]), .out(ct_w[1]), .o_vld(ovld_w[1]), .i_rdy(drv_rdy));
  aes_cipher_iter #(.NK(8)) u_nk8 (
    .i_clk(clk), .i_rst(rst), .i_vld(ivld_w[2]), .o_rdy(rdy_w[2]), .in(drv_pt),
    .i_key(drv_key), .out(ct_w[2]), .o_vld(ovld_w[2]), .i_rdy(drv_rdy));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] kmask(input logic [1:0] s);
    case (s)
      2'd0:    kmask = {{128{1'b1}}, 128'd0};
      2'd1:    kmask = {{192{1'b1}}, 64'd0};
      default: kmask = {256{1'b1}};
    endcase
  endfunction

  function automatic int full_lat(input logic [1:0] s);
    case (s)
      2'd0:    full_lat = 51;
      2'd1:    full_lat = 59;
      default: full_lat = 67;
    endcase
  endfunction

`ifdef AES_KEY_CACHE_EN
  function automatic int hit_lat(input logic [1:0] s);
    case (s)
      2'd0:    hit_lat = 11;
      2'd1:    hit_lat = 13;
      default: hit_lat = 15;
    endcase
  endfunction
`endif

  task automatic model_reset();
`ifdef AES_KEY_CACHE_EN
    for (int i = 0; i < 3; i++) begin
      mc_vld[i] = 1'b0;
      mc_key[i] = '0;
    end
`endif
    sb_q.delete();
  endtask

  // Drive one request, wait for acceptance, and queue the expected result.
  task automatic send(input logic [255:0] key, input logic [127:0] pt, input logic [127:0] ct,
                      output int acc);
    exp_t         e;
    logic [255:0] k;
    int           n;
    k = key & kmask(sel);
    @(negedge clk);
    drv_key = k;
    drv_pt  = pt;
    drv_vld = 1'b1;
    n = 0;
    while (!obs_rdy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!obs_rdy) check("accept_timeout", 128'(obs_rdy), 128'(1));
    acc   = cyc;
    e.ct  = ct;
    e.acc = acc;
    e.lat = full_lat(sel);
`ifdef AES_KEY_CACHE_EN
    if (mc_vld[sel] && mc_key[sel] == k) e.lat = hit_lat(sel);
    mc_vld[sel] = 1'b1;
    mc_key[sel] = k;
`endif
    sb_q.push_back(e);
    @(negedge clk);
    drv_vld = 1'b0;
    drv_pt  = {$urandom, $urandom, $urandom, $urandom};
    drv_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 128'(sb_q.size()), 128'(0));
      sb_q.delete();
    end
  endtask

  // Compare each ciphertext and its latency on the rising edge of o_vld.
  always @(negedge clk) begin
    if (rst) begin
      mon_prev = 1'b0;
    end else begin
      if (obs_vld && !mon_prev) begin
        if (sb_q.size() == 0) begin
          check("spurious_vld", 128'(obs_vld), 128'(0));
        end else begin
          mon_e = sb_q.pop_front();
          check("ciphertext", obs_out, mon_e.ct);
          check("latency", 128'(cyc - mon_e.acc), 128'(mon_e.lat));
        end
      end
      mon_prev = obs_vld;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, n;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_vld", 128'(obs_vld), 128'(0));
    check("rst_out", obs_out, 128'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 128'(obs_rdy), 128'(1));

    // NK=4: back-to-back same key, then new keys.
    sel = 2'd0;
    send(K_SEQ, PT_A, CT_A4, a1);
    send(K_SEQ, PT_A, CT_A4, a2);
    check("b2b_interval", 128'(a2 - a1), 128'(52));
    send(K_B, PT_B, CT_B4, a1);
    send(K_Z, PT_Z, CT_Z4, a1);
    drain();

    sel = 2'd1;
    send(K_SEQ, PT_A, CT_A6, a1);
    drain();

    sel = 2'd2;
    send(K_SEQ, PT_A, CT_A8, a1);
    send(K_Z, PT_Z, CT_Z8, a1);
    drain();

    // Downstream back-pressure in DONE.
    sel = 2'd0;
    drv_rdy = 1'b0;
    send(K_B, PT_B, CT_B4, a1);
    n = 0;
    while (!obs_vld && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      check("hold_vld", 128'(obs_vld), 128'(1));
      check("hold_out", obs_out, CT_B4);
      check("hold_rdy", 128'(obs_rdy), 128'(0));
      @(negedge clk);
    end
    drv_rdy = 1'b1;
    @(negedge clk);
    check("release_vld", 128'(obs_vld), 128'(0));
    check("release_rdy", 128'(obs_rdy), 128'(1));
    check("release_out", obs_out, CT_B4);
    drain();

    // Reset in the middle of the round phase.
    send(K_SEQ, PT_A, CT_A4, a1);
    repeat (44) @(negedge clk);
    check("busy_rdy", 128'(obs_rdy), 128'(0));
    #2 rst = 1'b1;
    #1;
    check("midrst_vld", 128'(obs_vld), 128'(0));
    check("midrst_out", obs_out, 128'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_midrst", 128'(obs_rdy), 128'(1));
    send(K_SEQ, PT_A, CT_A4, a1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_cipher_iter.md
AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

Interface
REQ-001 SHALL have parameter NK, default 4, meaning key length in 32-bit words; legal values 4/6/8 (AES-128/192/256).
REQ-002 SHALL derive localparam NR = NK+6 (round count) and NW = 4*(NR+1) (schedule words); neither is overridable.
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_vld  input  1  plaintext/key request valid.
REQ-006 SHALL have port o_rdy  output  1  core can accept a request.
REQ-007 SHALL have port in  input  128  plaintext; in[127:120] is state byte 0.
REQ-008 SHALL have port i_key  input  32*NK  cipher key; schedule word 0 is i_key[32*NK-1 -: 32].
REQ-009 SHALL have port out  output  128  ciphertext, same byte order as in.
REQ-010 SHALL have port o_vld  output  1  out holds a valid ciphertext.
REQ-011 SHALL have port i_rdy  input  1  downstream accepts out.

Function
REQ-012 SHALL implement FSM states IDLE, KEYEXP, ROUND, DONE.
REQ-013 SHALL assert o_rdy only in IDLE; accept is the cycle with i_vld && o_rdy.
REQ-014 SHALL, on accept, register state <= in XOR words 0..3, register key words 0..NK-1, clear the round counter, and go to KEYEXP.
REQ-015 SHALL, in KEYEXP, generate exactly one schedule word per cycle for index NK..NW-1 per FIPS-197 (RotWord/SubWord/Rcon when idx mod NK = 0; SubWord only when NK=8 and idx mod 8 = 4), i.e. E = NW-NK cycles (40/46/52).
REQ-016 SHALL, in ROUND, apply one round per cycle for r = 1..NR using words 4r..4r+3; rounds 1..NR-1 full, round NR without MixColumns.
REQ-017 SHALL enter DONE after round NR, load out, and hold o_vld=1 and out stable until i_rdy=1.
REQ-018 SHALL, on o_vld && i_rdy, drop o_vld the next cycle and return to IDLE; o_rdy rises that same cycle, so back-to-back throughput is one block per E+NR+2 cycles.
REQ-019 SHALL have latency: accept at cycle 0, o_vld first high at cycle E+NR+1 (51/59/67 for NK 4/6/8).
REQ-020 SHALL ignore in, i_key and i_vld outside IDLE; inputs are sampled only on accept.
REQ-021 SHALL keep out unchanged after o_vld falls until the next DONE entry.
REQ-022 SHALL use 4-bit round counter and 6-bit word index; no value beyond NR/NW-1 is ever reached.

Reset
REQ-023 SHALL, on i_rst high at any time, asynchronously force IDLE, o_vld=0, out=0, counters=0, key-cache flag=0; o_rdy=1 from the first clock edge after i_rst falls.
REQ-024 SHALL abandon any in-flight block on reset mid-operation; no partial result is ever presented.
REQ-025 SHALL leave the schedule word array unreset.

Configuration
REQ-026 SHALL support macro AES_KEY_CACHE_EN.
REQ-027 With AES_KEY_CACHE_EN defined: SHALL store the last fully expanded key and a cache-valid flag; on accept with i_key equal to it and flag=1, SHALL skip KEYEXP (latency NR+1: 11/13/15); flag set on KEYEXP completion, cleared by reset.
REQ-028 Without AES_KEY_CACHE_EN: SHALL always run KEYEXP; no compare logic or stored-key register exists.

Structure
REQ-029 SHALL place in package aes_pkg: S-box function, xtime function, Rcon table, FSM state enum typedef.
REQ-030 SHALL use one sub-module aes_round_comb: combinational SubBytes/ShiftRows/MixColumns(bypass on last flag)/AddRoundKey on 128-bit state plus 128-bit round key.

Verification
REQ-031 NK=4, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out 69c4e0d86a7b0430d8cdb78070b4c55a, o_vld at cycle 51.
REQ-032 NK=6, key 000102...1617, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191, o_vld at cycle 59.
REQ-033 NK=8, key 000102...1e1f, same pt -> 8ea2b7ca516745bfeafc49904b496089, o_vld at cycle 67.
REQ-034 Hold i_rdy=0 for 20 cycles in DONE -> o_vld and out stable, o_rdy=0; raise i_rdy -> o_vld low and o_rdy high next cycle.
REQ-035 Pulse i_rst during ROUND -> o_vld=0, out=0 immediately; subsequent REQ-031 stimulus yields the correct result.
REQ-036 With AES_KEY_CACHE_EN, NK=4: two back-to-back blocks with the same key -> second o_vld 11 cycles after its accept; changed key -> 51 cycles.
